// File: rtl/color_mixer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : color_mixer_pkg
// Brief    : Shared types and constants for the colour-mixer ADC and PWM sides.
// Revision : 1.0 - initial release
// ============================================================================
package color_mixer_pkg;

    localparam int DUTY_W = 8;

    localparam int NUM_CH = 3;
    localparam int CH_R   = 0;
    localparam int CH_G   = 1;
    localparam int CH_B   = 2;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } pend_state_t;

endpackage
`default_nettype wire

// File: rtl/rgb_pwm_driver_if.sv
`default_nettype none
// ============================================================================
// Interface : rgb_pwm_driver_if
// Brief     : Load/ack handshake, duty inputs and PWM outputs of rgb_pwm_driver.
// Revision  : 1.0 - initial release
// ============================================================================
interface rgb_pwm_driver_if
    import color_mixer_pkg::*;
#(
    parameter int WIDTH = DUTY_W
);
    logic             load;
    logic [WIDTH-1:0] duty_r;
    logic [WIDTH-1:0] duty_g;
    logic [WIDTH-1:0] duty_b;
    logic             of_r;
    logic             of_g;
    logic             of_b;
    logic             load_ack;
    logic             period_start;
    logic             pwm_r;
    logic             pwm_g;
    logic             pwm_b;

    modport master (
        output load, duty_r, duty_g, duty_b, of_r, of_g, of_b,
        input  load_ack, period_start, pwm_r, pwm_g, pwm_b
    );

    modport slave (
        input  load, duty_r, duty_g, duty_b, of_r, of_g, of_b,
        output load_ack, period_start, pwm_r, pwm_g, pwm_b
    );
endinterface
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// ============================================================================
// Module   : pwm_channel
// Brief    : One colour channel: pending/active duty+overflow and registered compare.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_channel #(
    parameter int WIDTH      = 8,
    parameter int ACTIVE_LOW = 0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_capture,
    input  wire logic             i_apply_in,
    input  wire logic             i_apply_pend,
    input  wire logic [WIDTH-1:0] i_duty,
    input  wire logic             i_of,
    input  wire logic [WIDTH-1:0] i_cnt,
    output logic                  o_pwm
);
    localparam logic c_POL = (ACTIVE_LOW != 0);

    logic [WIDTH-1:0] r_pend_duty;
    logic             r_pend_of;
    logic [WIDTH-1:0] r_act_duty;
    logic             r_act_of;
    logic             r_pwm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_duty <= '0;
            r_pend_of   <= 1'b0;
            r_act_duty  <= '0;
            r_act_of    <= 1'b0;
            r_pwm       <= c_POL;
        end else begin
            if (i_capture) begin
                r_pend_duty <= i_duty;
                r_pend_of   <= i_of;
            end
            // Active set only changes on the boundary edge, when cnt returns to 0.
            if (i_apply_in) begin
                r_act_duty <= i_duty;
                r_act_of   <= i_of;
            end else if (i_apply_pend) begin
                r_act_duty <= r_pend_duty;
                r_act_of   <= r_pend_of;
            end
            r_pwm <= (r_act_of | (i_cnt < r_act_duty)) ^ c_POL;
        end
    end

    assign o_pwm = r_pwm;

endmodule
`default_nettype wire

// File: rtl/rgb_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : rgb_pwm_driver
// Brief    : Three-channel PWM LED driver with period-aligned double-buffered duties.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_pwm_driver
    import color_mixer_pkg::*;
#(
    parameter int WIDTH      = DUTY_W,
    parameter int PRESCALE   = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  wire logic        clk,
    input  wire logic        reset,
    rgb_pwm_driver_if.slave  bus
);
    localparam int              c_PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(PRESCALE - 1);

    logic [c_PW-1:0]  r_presc;
    logic [WIDTH-1:0] r_cnt;
    logic             w_tick;
    logic             w_boundary;

    pend_state_t      r_state;
    pend_state_t      w_state_nxt;
    logic             w_capture;
    logic             w_apply_in;
    logic             w_apply_pend;
    logic             w_ack_nxt;

    logic             r_load_ack;
    logic             r_period_start;
    logic             r_post_reset;

    logic [WIDTH-1:0] w_duty_in [NUM_CH];
    logic             w_of_in   [NUM_CH];
    logic             w_pwm     [NUM_CH];

    assign w_tick     = (r_presc == c_PRESC_MAX);
    assign w_boundary = w_tick && (r_cnt == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_cnt   <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_cnt   <= r_cnt + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A load coinciding with the boundary bypasses the pending buffer entirely.
    always_comb begin
        w_state_nxt  = r_state;
        w_capture    = 1'b0;
        w_apply_in   = 1'b0;
        w_apply_pend = 1'b0;
        w_ack_nxt    = 1'b0;
        if (w_boundary) begin
            w_state_nxt = IDLE;
            if (bus.load) begin
                w_apply_in = 1'b1;
                w_ack_nxt  = 1'b1;
            end else if (r_state == PENDING) begin
                w_apply_pend = 1'b1;
                w_ack_nxt    = 1'b1;
            end
        end else if (bus.load) begin
            w_capture   = 1'b1;
            w_state_nxt = PENDING;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_load_ack     <= 1'b0;
            r_period_start <= 1'b0;
            r_post_reset   <= 1'b1;
        end else begin
            r_load_ack     <= w_ack_nxt;
            r_period_start <= w_boundary | r_post_reset;
            r_post_reset   <= 1'b0;
        end
    end

    assign w_duty_in[CH_R] = bus.duty_r;
    assign w_duty_in[CH_G] = bus.duty_g;
    assign w_duty_in[CH_B] = bus.duty_b;
    assign w_of_in[CH_R]   = bus.of_r;
    assign w_of_in[CH_G]   = bus.of_g;
    assign w_of_in[CH_B]   = bus.of_b;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        pwm_channel #(
            .WIDTH      (WIDTH),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk          (clk),
            .rst          (reset),
            .i_capture    (w_capture),
            .i_apply_in   (w_apply_in),
            .i_apply_pend (w_apply_pend),
            .i_duty       (w_duty_in[gi]),
            .i_of         (w_of_in[gi]),
            .i_cnt        (r_cnt),
            .o_pwm        (w_pwm[gi])
        );
    end

    assign bus.load_ack     = r_load_ack;
    assign bus.period_start = r_period_start;
    assign bus.pwm_r        = w_pwm[CH_R];
    assign bus.pwm_g        = w_pwm[CH_G];
    assign bus.pwm_b        = w_pwm[CH_B];

endmodule
`default_nettype wire

// File: tb/tb_rgb_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_pwm_driver
// Brief    : Self-checking bench for rgb_pwm_driver (active-high and active-low copies).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_pwm_driver;
    localparam int W   = 4;
    localparam int P   = 2;
    localparam int TOP = (1 << W);
    localparam int PER = P * TOP;

    logic         clk    = 1'b0;
    logic         reset  = 1'b1;
    logic         load   = 1'b0;
    logic [W-1:0] duty_r = '0;
    logic [W-1:0] duty_g = '0;
    logic [W-1:0] duty_b = '0;
    logic         of_r   = 1'b0;
    logic         of_g   = 1'b0;
    logic         of_b   = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rgb_pwm_driver_if #(.WIDTH(W)) bus_h ();
    rgb_pwm_driver_if #(.WIDTH(W)) bus_l ();

    assign bus_h.load = load;   assign bus_l.load = load;
    assign bus_h.duty_r = duty_r; assign bus_l.duty_r = duty_r;
    assign bus_h.duty_g = duty_g; assign bus_l.duty_g = duty_g;
    assign bus_h.duty_b = duty_b; assign bus_l.duty_b = duty_b;
    assign bus_h.of_r = of_r;   assign bus_l.of_r = of_r;
    assign bus_h.of_g = of_g;   assign bus_l.of_g = of_g;
    assign bus_h.of_b = of_b;   assign bus_l.of_b = of_b;

    rgb_pwm_driver #(.WIDTH(W), .PRESCALE(P), .ACTIVE_LOW(0)) dut_h (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_h)
    );

    rgb_pwm_driver #(.WIDTH(W), .PRESCALE(P), .ACTIVE_LOW(1)) dut_l (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_l)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: position in the period follows from the number of clocks since reset.
    int   n           = 0;
    bit   model_valid = 1'b0;
    int   act_d  [3];
    bit   act_o  [3];
    int   pend_d [3];
    bit   pend_o [3];
    bit   pend_v;
    bit   exp_ack;
    bit   exp_ps;
    bit   exp_pwm[3];

    initial begin
        int  cnt_v;
        int  presc_v;
        bit  bnd;
        int  in_d[3];
        bit  in_o[3];
        forever begin
            @(posedge clk);
            in_d[0] = int'(duty_r); in_d[1] = int'(duty_g); in_d[2] = int'(duty_b);
            in_o[0] = of_r;         in_o[1] = of_g;         in_o[2] = of_b;
            if (reset) begin
                n = 0;
                for (int c = 0; c < 3; c++) begin
                    act_d[c] = 0; act_o[c] = 1'b0; exp_pwm[c] = 1'b0;
                end
                pend_v      = 1'b0;
                exp_ack     = 1'b0;
                exp_ps      = 1'b0;
                model_valid = 1'b1;
            end else begin
                presc_v = n % P;
                cnt_v   = (n / P) % TOP;
                bnd     = (presc_v == P - 1) && (cnt_v == TOP - 1);
                for (int c = 0; c < 3; c++)
                    exp_pwm[c] = act_o[c] || (cnt_v < act_d[c]);
                exp_ps  = bnd || (n == 0);
                exp_ack = bnd && (load || pend_v);
                if (bnd) begin
                    for (int c = 0; c < 3; c++) begin
                        if (load) begin
                            act_d[c] = in_d[c]; act_o[c] = in_o[c];
                        end else if (pend_v) begin
                            act_d[c] = pend_d[c]; act_o[c] = pend_o[c];
                        end
                    end
                    pend_v = 1'b0;
                end else if (load) begin
                    for (int c = 0; c < 3; c++) begin
                        pend_d[c] = in_d[c]; pend_o[c] = in_o[c];
                    end
                    pend_v = 1'b1;
                end
                n++;
            end
        end
    end

    // Per-cycle comparison of both DUT copies against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (model_valid) begin
                chk("ack_h", int'(bus_h.load_ack), int'(exp_ack));
                chk("ps_h",  int'(bus_h.period_start), int'(exp_ps));
                chk("pwm_r_h", int'(bus_h.pwm_r), int'(exp_pwm[0]));
                chk("pwm_g_h", int'(bus_h.pwm_g), int'(exp_pwm[1]));
                chk("pwm_b_h", int'(bus_h.pwm_b), int'(exp_pwm[2]));
                chk("ack_l", int'(bus_l.load_ack), int'(exp_ack));
                chk("ps_l",  int'(bus_l.period_start), int'(exp_ps));
                chk("pwm_r_l", int'(bus_l.pwm_r), int'(!exp_pwm[0]));
                chk("pwm_g_l", int'(bus_l.pwm_g), int'(!exp_pwm[1]));
                chk("pwm_b_l", int'(bus_l.pwm_b), int'(!exp_pwm[2]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int r, input int g, input int b,
                           input bit or_, input bit og, input bit ob);
        duty_r = W'(r); duty_g = W'(g); duty_b = W'(b);
        of_r = or_; of_g = og; of_b = ob;
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic wait_ps();
        bit got = 1'b0;
        for (int t = 0; t < 4 * PER && !got; t++) begin
            @(negedge clk);
            got = bus_h.period_start;
        end
        if (!got) chk("period_start_timeout", 0, 1);
    endtask

    // Counts over one period: acks from its first clk, PWM highs over the 32 clks after.
    task automatic measure(output int hr, output int hg, output int hb,
                           output int lr_low, output int acks);
        hr = 0; hg = 0; hb = 0; lr_low = 0; acks = 0;
        wait_ps();
        for (int i = 0; i <= PER; i++) begin
            if (i > 0) @(negedge clk);
            if (i < PER) acks += int'(bus_h.load_ack);
            if (i > 0) begin
                hr     += int'(bus_h.pwm_r);
                hg     += int'(bus_h.pwm_g);
                hb     += int'(bus_h.pwm_b);
                lr_low += int'(!bus_l.pwm_r);
            end
        end
    endtask

    initial begin
        int hr, hg, hb, lr, ak;

        repeat (3) cyc();
        reset = 1'b0;

        for (int p = 0; p < 3; p++) begin
            measure(hr, hg, hb, lr, ak);
            chk("idle_r", hr, 0); chk("idle_g", hg, 0); chk("idle_b", hb, 0);
            chk("idle_l_low", lr, 0); chk("idle_ack", ak, 0);
        end

        do_load(4, 0, 15, 1'b0, 1'b0, 1'b0);
        measure(hr, hg, hb, lr, ak);
        chk("mid_ack", ak, 1); chk("mid_r", hr, 8); chk("mid_g", hg, 0);
        chk("mid_b", hb, 30); chk("mid_l_low", lr, 8);
        measure(hr, hg, hb, lr, ak);
        chk("hold_ack", ak, 0); chk("hold_r", hr, 8); chk("hold_b", hb, 30);

        do_load(4, 3, 15, 1'b0, 1'b1, 1'b0);
        measure(hr, hg, hb, lr, ak);
        chk("of_ack", ak, 1); chk("of_g", hg, PER);

        do_load(2, 3, 15, 1'b0, 1'b1, 1'b0);
        repeat (3) cyc();
        do_load(9, 3, 15, 1'b0, 1'b1, 1'b0);
        measure(hr, hg, hb, lr, ak);
        chk("two_ack", ak, 1); chk("two_r", hr, 18); chk("two_g", hg, PER);

        wait_ps();
        repeat (5) cyc();
        do_load(1, 0, 0, 1'b0, 1'b0, 1'b0);
        repeat (25) cyc();
        do_load(6, 0, 0, 1'b0, 1'b0, 1'b0);
        measure(hr, hg, hb, lr, ak);
        chk("bnd_ack", ak, 1); chk("bnd_r", hr, 12); chk("bnd_l_low", lr, 12);

        cyc();
        do_load(13, 5, 5, 1'b0, 1'b0, 1'b0);
        cyc();
        reset = 1'b1;
        cyc();
        @(negedge clk);
        chk("rst_pwm_r_h", int'(bus_h.pwm_r), 0);
        chk("rst_pwm_r_l", int'(bus_l.pwm_r), 1);
        chk("rst_ps", int'(bus_h.period_start), 0);
        cyc();
        reset = 1'b0;
        for (int p = 0; p < 2; p++) begin
            measure(hr, hg, hb, lr, ak);
            chk("post_rst_ack", ak, 0); chk("post_rst_r", hr, 0); chk("post_rst_l_low", lr, 0);
        end

        for (int i = 0; i < 12 * PER; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                duty_r = W'($urandom_range(0, TOP - 1));
                duty_g = W'($urandom_range(0, TOP - 1));
                duty_b = W'($urandom_range(0, TOP - 1));
                of_r = ($urandom_range(0, 3) == 0);
                of_g = ($urandom_range(0, 3) == 0);
                of_b = ($urandom_range(0, 3) == 0);
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            cyc();
        end
        load = 1'b0;
        repeat (PER) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
